// File: rtl/burst_write_ctrl.sv
// burst_write_ctrl
//   Sequences one burst of host words into MRAM through a single_reg staging
//   register. A start command latches a base address and a word count; each
//   word is pulled over a valid/ready handshake, loaded into the staging
//   register, then the MRAM write strobe is held for WR_CYCLES cycles.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   start                burst request, sampled only in IDLE
//   base_addr, burst_len first MRAM word address and word count, latched with start
//   in_valid, in_data    host word stream
//   in_ready             controller can accept a word (LOAD)
//   reg_wen, reg_data    single_reg write enable / data (pass-through)
//   mram_addr, mram_we   MRAM word address (registered) and write strobe (WRITE)
//   busy                 high in every state except IDLE
//   done                 one-cycle pulse at burst completion
module burst_write_ctrl #(
    parameter int unsigned BUS_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned WR_CYCLES  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic                  in_valid,
    input  logic [BUS_WIDTH-1:0]  in_data,
    output logic                  in_ready,
    output logic                  reg_wen,
    output logic [BUS_WIDTH-1:0]  reg_data,
    output logic [ADDR_WIDTH-1:0] mram_addr,
    output logic                  mram_we,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned    CNT_W    = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WR_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  words_left;
    logic [CNT_W-1:0]      cycle_cnt;

    logic launch;
    logic strobe_last;
    logic last_word;

    // A zero-length request is dropped here so it never leaves IDLE.
    assign launch      = start && (burst_len != '0);
    assign strobe_last = (cycle_cnt == CNT_LAST);
    assign last_word   = (words_left == LEN_WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch)   state_nxt = LOAD;
            LOAD:    if (in_valid) state_nxt = WRITE;
            WRITE:   if (strobe_last) state_nxt = last_word ? DONE : LOAD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr       <= '0;
            words_left <= '0;
            cycle_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        addr       <= base_addr;
                        words_left <= burst_len;
                    end
                end
                LOAD: begin
                    if (in_valid) cycle_cnt <= '0;
                end
                WRITE: begin
                    // Saturate at the last strobe cycle; LOAD clears it for the next word.
                    if (!strobe_last) begin
                        cycle_cnt <= cycle_cnt + CNT_W'(1);
                    end else if (!last_word) begin
                        addr       <= addr + ADDR_WIDTH'(1);
                        words_left <= words_left - LEN_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == LOAD);
    assign reg_wen   = in_valid && in_ready;
    assign reg_data  = in_data;
    assign mram_addr = addr;
    assign mram_we   = (state == WRITE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_burst_write_ctrl.sv
module tb_burst_write_ctrl;

    localparam int unsigned BW     = 16;
    localparam int unsigned AW     = 10;
    localparam int unsigned LW     = 8;
    localparam int unsigned WRC    = 4;
    localparam int          BUDGET = 3000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] burst_len = '0;
    logic          in_valid = 1'b0;
    logic [BW-1:0] in_data = '0;
    logic          in_ready;
    logic          reg_wen;
    logic [BW-1:0] reg_data;
    logic [AW-1:0] mram_addr;
    logic          mram_we;
    logic          busy;
    logic          done;

    burst_write_ctrl #(
        .BUS_WIDTH (BW),
        .ADDR_WIDTH(AW),
        .LEN_WIDTH (LW),
        .WR_CYCLES (WRC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_addr(base_addr),
        .burst_len(burst_len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .reg_wen  (reg_wen),
        .reg_data (reg_data),
        .mram_addr(mram_addr),
        .mram_we  (mram_we),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: one entry per word, pushed when the word is presented.
    typedef struct {
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
    } exp_t;
    exp_t q[$];

    logic [BW-1:0] staged = '0;
    logic          prev_we = 1'b0;
    logic          prev_done = 1'b0;
    int            we_len = 0;

    // Monitor at the falling edge: staging register model + strobe checks.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_we   = 1'b0;
            prev_done = 1'b0;
            we_len    = 0;
        end else begin
            if (mram_we && !prev_we) begin
                if (q.size() == 0) begin
                    chk("sb_unexpected_write", 32'(mram_addr), 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("sb_addr", 32'(mram_addr), 32'(e.addr));
                    chk("sb_data", 32'(staged), 32'(e.data));
                end
                we_len = 1;
            end else if (mram_we) begin
                we_len++;
            end else if (prev_we) begin
                chk("we_width", 32'(we_len), 32'(WRC));
            end
            if (done && prev_done) chk("done_one_cycle", 32'(done), 32'd0);
            if (reg_wen) staged = reg_data;
            prev_we   = mram_we;
            prev_done = done;
        end
    end

    typedef struct {
        logic [AW-1:0] base;
        logic [LW-1:0] len;
        logic [BW-1:0] data0;
        logic [BW-1:0] dstep;
        int            gap;
        int            gap_word;
        bit            poke;   // start pulse while WRITE
        bit            dstart; // start pulse in the DONE cycle
        int            cycles; // start cycle through done cycle inclusive
    } vec_t;

    task automatic run_burst(input vec_t v);
        int            t;
        int            w;
        int            gaps;
        bit            poked;
        logic [AW-1:0] ea;
        w     = 0;
        gaps  = 0;
        poked = 1'b0;
        start     = 1'b1;
        base_addr = v.base;
        burst_len = v.len;
        in_valid  = 1'b0;
        tick();
        start = 1'b0;
        t = 1;
        while (t < BUDGET && !done) begin
            start = 1'b0;
            if (in_ready && w < int'(v.len)) begin
                ea = v.base + AW'(w);
                if (w == v.gap_word && gaps < v.gap) begin
                    chk("bp_no_we", 32'(mram_we), 32'd0);
                    chk("bp_addr", 32'(mram_addr), 32'(ea));
                    in_valid = 1'b0;
                    gaps++;
                end else begin
                    in_valid = 1'b1;
                    in_data  = v.data0 + BW'(w) * v.dstep;
                    q.push_back('{addr: ea, data: in_data});
                    w++;
                end
            end else begin
                // Word offered outside LOAD must not be consumed.
                if (mram_we) chk("no_wen_in_write", 32'(reg_wen), 32'd0);
                in_valid = 1'b1;
                in_data  = 16'hDEAD;
                if (v.poke && mram_we && !poked) begin
                    start     = 1'b1;
                    base_addr = 10'h2AA;
                    burst_len = 8'd7;
                    poked     = 1'b1;
                end
            end
            tick();
            t++;
        end
        in_valid = 1'b0;
        chk("done_seen", 32'(t < BUDGET), 32'd1);
        chk("latency", 32'(t + 1), 32'(v.cycles));
        chk("words_sent", 32'(w), 32'(v.len));
        chk("sb_drained", 32'(q.size()), 32'd0);
        chk("done_busy", 32'(busy), 32'd1);
        if (v.dstart) begin
            start     = 1'b1;
            base_addr = 10'h333;
            burst_len = 8'd1;
        end
        tick();
        start = 1'b0;
        chk("idle_after_done", 32'(busy), 32'd0);
        chk("done_dropped", 32'(done), 32'd0);
    endtask

    vec_t vecs[5];

    initial begin
        int k;
        vecs[0] = '{base: 10'h010, len: 8'd1,   data0: 16'hBEEF, dstep: 16'h0000, gap: 0, gap_word: 0, poke: 1'b0, dstart: 1'b1, cycles: 7};
        vecs[1] = '{base: 10'h020, len: 8'd3,   data0: 16'h1111, dstep: 16'h1111, gap: 0, gap_word: 0, poke: 1'b1, dstart: 1'b0, cycles: 17};
        vecs[2] = '{base: 10'h040, len: 8'd2,   data0: 16'hA000, dstep: 16'h0001, gap: 5, gap_word: 1, poke: 1'b0, dstart: 1'b1, cycles: 17};
        vecs[3] = '{base: 10'h3FF, len: 8'd2,   data0: 16'h5A5A, dstep: 16'h0101, gap: 0, gap_word: 0, poke: 1'b0, dstart: 1'b1, cycles: 12};
        vecs[4] = '{base: 10'h3C0, len: 8'd255, data0: 16'h0000, dstep: 16'h0003, gap: 2, gap_word: 0, poke: 1'b0, dstart: 1'b0, cycles: 1279};

        // Reset state, with a word offered to prove it is not accepted.
        in_valid = 1'b1;
        in_data  = 16'h1234;
        repeat (2) tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_reg_wen", 32'(reg_wen), 32'd0);
        chk("rst_mram_we", 32'(mram_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", 32'(mram_addr), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();

        // Zero-length start is ignored.
        start     = 1'b1;
        base_addr = 10'h155;
        burst_len = 8'd0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("len0_busy", 32'(busy), 32'd0);
            chk("len0_done", 32'(done), 32'd0);
            tick();
        end

        for (int i = 0; i < 5; i++) run_burst(vecs[i]);

        // Reset in the middle of a WRITE.
        start     = 1'b1;
        base_addr = 10'h060;
        burst_len = 8'd2;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h7777;
        chk("rw_ready", 32'(in_ready), 32'd1);
        q.push_back('{addr: 10'h060, data: 16'h7777});
        tick();
        in_valid = 1'b0;
        k = 0;
        while (!mram_we && k < 10) begin
            tick();
            k++;
        end
        chk("rw_in_write", 32'(mram_we), 32'd1);
        tick();
        rst = 1'b1;
        #1;
        chk("rw_we_drop", 32'(mram_we), 32'd0);
        chk("rw_busy_drop", 32'(busy), 32'd0);
        chk("rw_ready_drop", 32'(in_ready), 32'd0);
        chk("rw_addr_clear", 32'(mram_addr), 32'd0);
        chk("rw_no_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post_rst_idle", 32'(busy | done | mram_we), 32'd0);
        end
        chk("rw_sb_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
